fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Ports SHALL be: clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 imem_address  output  16  instruction memory byte address; equals the current fetch PC.
REQ-004 imem_read  output  1  instruction memory read request, held until imem_resp.
REQ-005 imem_rdata  input  16  instruction word, valid only when imem_resp=1.
REQ-006 imem_resp  input  1  single-cycle read completion.
REQ-007 stall  input  1  IF/ID register must hold its contents (hazard from ID/EX).
REQ-008 redirect  input  1  taken-branch/jump flush request from MEM/WB.
REQ-009 redirect_pc  input  16  new fetch target, valid when redirect=1.
REQ-010 if_id_instruction  output  16  registered instruction presented to the decoder.
REQ-011 if_id_pc  output  16  registered PC+2 of that instruction.
REQ-012 if_id_valid  output  1  if_id_instruction is a real instruction, not a bubble.

Function
REQ-013 States SHALL be FETCH (request outstanding), HOLD (word buffered, downstream stalled), DISCARD (squashing a request made stale by redirect).
REQ-014 imem_read SHALL be 1 in FETCH and DISCARD, 0 in HOLD.
REQ-015 imem_address SHALL remain stable while imem_read=1 and imem_resp=0, including DISCARD.
REQ-016 FETCH, imem_resp=1, stall=0, redirect=0: next edge load if_id_instruction=imem_rdata, if_id_pc=pc+2, if_id_valid=1, pc<=pc+2, stay FETCH (one instruction per resp cycle).
REQ-017 FETCH, imem_resp=1, stall=1, redirect=0: capture imem_rdata and pc+2 into the hold buffer, pc<=pc+2, go HOLD; IF/ID unchanged.
REQ-018 FETCH/HOLD, stall=1, redirect=0: IF/ID outputs SHALL not change.
REQ-019 HOLD, stall=0, redirect=0: hold buffer to IF/ID with if_id_valid=1, go FETCH.
REQ-020 redirect=1 SHALL override stall in every state: next edge pc<=redirect_pc, if_id_instruction<=NOP (16'h0000), if_id_valid<=0, hold buffer discarded.
REQ-021 Redirect in FETCH with imem_resp=0: go DISCARD; in DISCARD, on imem_resp=1 drop the data and go FETCH at the new pc.
REQ-022 Redirect in FETCH with imem_resp=1, or in HOLD: drop data, go FETCH directly.
REQ-023 Redirect in DISCARD: replace target pc with redirect_pc; stay DISCARD unless imem_resp=1 (then FETCH).
REQ-024 PC arithmetic SHALL be 16-bit unsigned, wrapping 16'hFFFE+2 -> 16'h0000; bit 0 of pc is never set by increment; redirect_pc bit 0 is passed through unmodified.
REQ-025 In FETCH with stall=0 and imem_resp=0, IF/ID SHALL load a bubble (NOP, valid=0).

Reset
REQ-026 On rst_n=0, immediately: pc=16'h0000, state=FETCH, if_id_instruction=16'h0000, if_id_pc=16'h0000, if_id_valid=0, hold buffer cleared.
REQ-027 Reset asserted mid-request SHALL abandon it; after release, first request is to address 16'h0000 with imem_read=1.

Structure
REQ-028 lc3b_types SHALL gain lc3b_fetch_state enum (FETCH, HOLD, DISCARD) and constant lc3b_nop = 16'h0000; ports use lc3b_word.
REQ-029 The PC SHALL be one instance of the existing width-parameterised register sub-module "register" with load and async active-low clear; the rest is local.

Verification
REQ-030 Reset release, resp every cycle, rdata 16'h1234,16'h5678 -> if_id_instruction 1234/if_id_pc 0002 then 5678/0004, valid=1, imem_address 0000,0002,0004.
REQ-031 stall=1 on resp with rdata 16'hABCD at pc 0x0010 -> IF/ID frozen, imem_read=0; stall=0 -> ABCD/0x0012 presented, next address 0x0012.
REQ-032 redirect=1 to 0x3000 while request to 0x0020 outstanding -> DISCARD, address stays 0x0020 until resp, data dropped, valid=0, then address 0x3000.
REQ-033 redirect=1 with stall=1 in HOLD -> bubble (0000, valid=0), next address = redirect_pc.
REQ-034 pc 0xFFFE, resp -> if_id_pc 0x0000, next address 0x0000.
REQ-035 rst_n low during outstanding read -> outputs reset without clock edge; restart at 0x0000.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: machine word, fetch FSM states and the NOP encoding.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } lc3b_fetch_state;

    localparam lc3b_word lc3b_nop = 16'h0000;

    // Sequential fetch step; wraps naturally at 16 bits and never touches bit 0.
    function automatic lc3b_word pc_inc(input lc3b_word pc);
        return pc + 16'd2;
    endfunction

endpackage

// File: rtl/register.sv
// Width-parameterised load register with asynchronous active-low clear.
module register #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) data_d = data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= '0;
        else        data_q <= data_d;
    end

    assign data_out = data_q;

endmodule

// File: rtl/fetch_stage.sv
// LC-3b instruction fetch: drives instruction memory and fills the IF/ID register,
// buffering one word under stall and squashing stale requests after a redirect.
module fetch_stage
    import lc3b_types::*;
(
    input  logic     clk,
    input  logic     rst_n,
    output lc3b_word imem_address,
    output logic     imem_read,
    input  lc3b_word imem_rdata,
    input  logic     imem_resp,
    input  logic     stall,
    input  logic     redirect,
    input  lc3b_word redirect_pc,
    output lc3b_word if_id_instruction,
    output lc3b_word if_id_pc,
    output logic     if_id_valid
);

    lc3b_fetch_state state_q, state_d;
    lc3b_word        pc_q, pc_d, pc_next;
    logic            pc_load;
    lc3b_word        disc_addr_q, disc_addr_d;
    lc3b_word        hold_instr_q, hold_instr_d;
    lc3b_word        hold_pc_q, hold_pc_d;
    lc3b_word        if_id_instr_q, if_id_instr_d;
    lc3b_word        if_id_pc_q, if_id_pc_d;
    logic            if_id_valid_q, if_id_valid_d;

    register #(.DATA_W(16)) pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pc_load),
        .data_in  (pc_d),
        .data_out (pc_q)
    );

    assign pc_next = pc_inc(pc_q);

    // While squashing, the bus keeps the stale address; pc already holds the new target.
    assign imem_address = (state_q == DISCARD) ? disc_addr_q : pc_q;
    assign imem_read    = (state_q != HOLD);

    always_comb begin
        state_d       = state_q;
        pc_load       = 1'b0;
        pc_d          = pc_q;
        disc_addr_d   = disc_addr_q;
        hold_instr_d  = hold_instr_q;
        hold_pc_d     = hold_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_valid_d = if_id_valid_q;

        if (redirect) begin
            pc_load       = 1'b1;
            pc_d          = redirect_pc;
            if_id_instr_d = lc3b_nop;
            if_id_valid_d = 1'b0;
            hold_instr_d  = lc3b_nop;
            hold_pc_d     = '0;
            case (state_q)
                FETCH: begin
                    state_d     = imem_resp ? FETCH : DISCARD;
                    disc_addr_d = pc_q;
                end
                HOLD:    state_d = FETCH;
                DISCARD: state_d = imem_resp ? FETCH : DISCARD;
                default: state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_resp) begin
                        pc_load = 1'b1;
                        pc_d    = pc_next;
                        if (stall) begin
                            hold_instr_d = imem_rdata;
                            hold_pc_d    = pc_next;
                            state_d      = HOLD;
                        end else begin
                            if_id_instr_d = imem_rdata;
                            if_id_pc_d    = pc_next;
                            if_id_valid_d = 1'b1;
                        end
                    end else if (!stall) begin
                        if_id_instr_d = lc3b_nop;
                        if_id_valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_id_instr_d = hold_instr_q;
                        if_id_pc_d    = hold_pc_q;
                        if_id_valid_d = 1'b1;
                        state_d       = FETCH;
                    end
                end
                DISCARD: begin
                    if (imem_resp) state_d = FETCH;
                    if (!stall) begin
                        if_id_instr_d = lc3b_nop;
                        if_id_valid_d = 1'b0;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH;
            disc_addr_q   <= '0;
            hold_instr_q  <= lc3b_nop;
            hold_pc_q     <= '0;
            if_id_instr_q <= lc3b_nop;
            if_id_pc_q    <= '0;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            disc_addr_q   <= disc_addr_d;
            hold_instr_q  <= hold_instr_d;
            hold_pc_q     <= hold_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign if_id_instruction = if_id_instr_q;
    assign if_id_pc          = if_id_pc_q;
    assign if_id_valid       = if_id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a memory model answers requests, accepted fetches
// are queued in program order, and a monitor checks every instruction the decoder consumes.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] imem_address;
    logic        imem_read;
    logic [15:0] imem_rdata = 16'h0000;
    logic        imem_resp = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] if_id_instruction;
    logic [15:0] if_id_pc;
    logic        if_id_valid;

    fetch_stage dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .imem_address      (imem_address),
        .imem_read         (imem_read),
        .imem_rdata        (imem_rdata),
        .imem_resp         (imem_resp),
        .stall             (stall),
        .redirect          (redirect),
        .redirect_pc       (redirect_pc),
        .if_id_instruction (if_id_instruction),
        .if_id_pc          (if_id_pc),
        .if_id_valid       (if_id_valid)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model_pc = 16'h0000;
    logic        stale = 1'b0;

    // Memory contents are a fixed function of the address.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; bookkeeping runs after the monitor has sampled this cycle.
    task automatic cycle(input bit r, input bit s, input bit d, input logic [15:0] t);
        @(negedge clk);
        imem_resp   = r && (imem_read === 1'b1);
        imem_rdata  = imem_resp ? mem_word(imem_address) : 16'($urandom);
        stall       = s;
        redirect    = d;
        redirect_pc = t;
        #2;
        if (d) begin
            exp_q.delete();
            stale    = imem_read && !imem_resp;
            model_pc = t;
        end else if (imem_resp) begin
            if (stale) stale = 1'b0;
            else begin
                chk("fetch_addr", imem_address, model_pc);
                exp_q.push_back(model_pc);
                model_pc = 16'(model_pc + 16'd2);
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n     = 1'b0;
        imem_resp = 1'b0;
        stall     = 1'b0;
        redirect  = 1'b0;
        #1;
        chk("rst_instr", if_id_instruction, 16'h0000);
        chk("rst_pc", if_id_pc, 16'h0000);
        chk("rst_valid", 16'(if_id_valid), 16'h0000);
        chk("rst_addr", imem_address, 16'h0000);
        chk("rst_read", 16'(imem_read), 16'h0001);
        exp_q.delete();
        model_pc = 16'h0000;
        stale    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    logic        exp_bubble = 1'b0;
    logic        prev_pending = 1'b0;
    logic [15:0] prev_addr = 16'h0000;

    always @(negedge clk) begin
        logic [15:0] p;
        #1;
        if (!rst_n) begin
            exp_bubble   = 1'b0;
            prev_pending = 1'b0;
        end else begin
            if (exp_bubble) begin
                chk("flush_valid", 16'(if_id_valid), 16'h0000);
                chk("flush_instr", if_id_instruction, 16'h0000);
            end
            if (prev_pending) chk("addr_stable", imem_address, prev_addr);
            if (if_id_valid === 1'b1 && !stall) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL consume: got valid pc %h expected no instruction", if_id_pc);
                end else begin
                    p = exp_q.pop_front();
                    chk("if_id_pc", if_id_pc, 16'(p + 16'd2));
                    chk("if_id_instr", if_id_instruction, mem_word(p));
                end
            end
            exp_bubble   = redirect;
            prev_pending = (imem_read === 1'b1) && !imem_resp;
            prev_addr    = imem_address;
        end
    end

    initial begin
        logic [15:0] t;
        do_reset();

        // Back-to-back fetches from reset.
        cycle(1, 0, 0, 16'h0);
        after_edge();
        chk("seq0_instr", if_id_instruction, mem_word(16'h0000));
        chk("seq0_pc", if_id_pc, 16'h0002);
        chk("seq0_addr", imem_address, 16'h0002);
        cycle(1, 0, 0, 16'h0);
        after_edge();
        chk("seq1_instr", if_id_instruction, mem_word(16'h0002));
        chk("seq1_pc", if_id_pc, 16'h0004);
        chk("seq1_addr", imem_address, 16'h0004);

        // Stall on response buffers the word.
        cycle(1, 0, 1, 16'h0010);
        after_edge();
        chk("jmp_addr", imem_address, 16'h0010);
        cycle(1, 1, 0, 16'h0);
        after_edge();
        chk("hold_read", 16'(imem_read), 16'h0000);
        cycle(0, 1, 0, 16'h0);
        after_edge();
        chk("hold_read2", 16'(imem_read), 16'h0000);
        cycle(0, 0, 0, 16'h0);
        after_edge();
        chk("unhold_instr", if_id_instruction, mem_word(16'h0010));
        chk("unhold_pc", if_id_pc, 16'h0012);
        chk("unhold_valid", 16'(if_id_valid), 16'h0001);
        chk("unhold_addr", imem_address, 16'h0012);

        // Redirect while a request is outstanding.
        cycle(1, 0, 1, 16'h0020);
        cycle(0, 0, 1, 16'h3000);
        after_edge();
        chk("disc_addr", imem_address, 16'h0020);
        chk("disc_read", 16'(imem_read), 16'h0001);
        cycle(0, 0, 0, 16'h0);
        after_edge();
        chk("disc_addr2", imem_address, 16'h0020);
        cycle(1, 0, 0, 16'h0);
        after_edge();
        chk("disc_drop_valid", 16'(if_id_valid), 16'h0000);
        chk("disc_new_addr", imem_address, 16'h3000);

        // Redirect overrides stall in HOLD.
        cycle(1, 1, 0, 16'h0);
        cycle(0, 1, 1, 16'h4000);
        after_edge();
        chk("hold_redir_valid", 16'(if_id_valid), 16'h0000);
        chk("hold_redir_instr", if_id_instruction, 16'h0000);
        chk("hold_redir_addr", imem_address, 16'h4000);

        // PC wrap.
        cycle(1, 0, 1, 16'hFFFE);
        cycle(1, 0, 0, 16'h0);
        after_edge();
        chk("wrap_pc", if_id_pc, 16'h0000);
        chk("wrap_instr", if_id_instruction, mem_word(16'hFFFE));
        chk("wrap_addr", imem_address, 16'h0000);

        // Reset during an outstanding read.
        cycle(1, 0, 1, 16'h0100);
        cycle(0, 0, 0, 16'h0);
        do_reset();
        cycle(1, 0, 0, 16'h0);
        after_edge();
        chk("restart_pc", if_id_pc, 16'h0002);
        chk("restart_instr", if_id_instruction, mem_word(16'h0000));

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            case ($urandom_range(0, 9))
                0:       t = 16'hFFF8 + 16'(2 * $urandom_range(0, 3));
                1:       t = 16'($urandom) | 16'h0001;
                default: t = 16'($urandom) & 16'hFFFE;
            endcase
            cycle($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
                  $urandom_range(0, 19) == 0, t);
        end
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
